// File: rtl/sec_monitor_ctrl_if.sv
// Host word stream and shared table-RAM write port of the security monitor controller.
interface sec_monitor_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        bbr_we;
    logic [3:0]        nhr_we;

    // Host / RAM side: supplies words, observes the RAM write port.
    modport master (
        output wr_valid, wr_data,
        input  wr_ready, mem_sel, mem_addr, mem_wdata, bbr_we, nhr_we
    );

    // Controller side: accepts words, drives the RAM write port.
    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, mem_sel, mem_addr, mem_wdata, bbr_we, nhr_we
    );
endinterface

// File: rtl/sec_monitor_ctrl.sv
// Security monitor sequencer: loads bb/next-hop tables, releases the monitor,
// then gates and counts drop_packet alarms.
module sec_monitor_ctrl #(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 core_sp_clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic [ADDR_W:0]      load_len,
    sec_monitor_ctrl_if.slave    bus,
    output logic                 mon_reset,
    input  logic                 drop_packet,
    output logic                 pkt_drop,
    output logic                 alarm,
    input  logic                 alarm_clear,
    output logic [CNT_W-1:0]     alarm_count,
    output logic [DATA_W-1:0]    load_checksum,
    output logic                 load_done,
    output logic                 busy
);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned MAX_LEN = 1 << ADDR_W;
    localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_BB, LOAD_NH, SETTLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [LEN_W-1:0]    start_len;
    logic                accept;
    logic                counted;
    logic                sel_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [3:0]          bbr_we_d, nhr_we_d;
    logic                mon_reset_d, pkt_drop_d, alarm_d, load_done_d;
    logic [CNT_W-1:0]    count_d;
    logic [DATA_W-1:0]   csum_d;

    // Table length clamped to the RAM depth.
    assign start_len = (load_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : load_len;

    // Ready and busy decode the current state directly.
    assign bus.wr_ready = (state_q == LOAD_BB) || (state_q == LOAD_NH);
    assign busy         = (state_q != IDLE) && (state_q != RUN);
    assign accept       = bus.wr_valid && bus.wr_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        settle_d    = settle_q;
        sel_d       = bus.mem_sel;
        addr_d      = bus.mem_addr;
        wdata_d     = bus.mem_wdata;
        bbr_we_d    = '0;
        nhr_we_d    = '0;
        mon_reset_d = mon_reset;
        pkt_drop_d  = 1'b0;
        alarm_d     = alarm;
        count_d     = alarm_count;
        csum_d      = load_checksum;
        load_done_d = 1'b0;
        counted     = 1'b0;

        case (state_q)
            IDLE, RUN: begin
                if (state_q == RUN) begin
                    pkt_drop_d = drop_packet;
                    counted    = drop_packet;
                    if (drop_packet) begin
                        alarm_d = 1'b1;
                        if (alarm_count != '1) begin
                            count_d = alarm_count + CNT_W'(1);
                        end
                    end
                end
                if (load_start && (load_len != '0)) begin
                    state_d     = LOAD_BB;
                    cnt_d       = '0;
                    len_d       = start_len;
                    csum_d      = '0;
                    mon_reset_d = 1'b1;
                    sel_d       = 1'b1;
                end
            end
            LOAD_BB, LOAD_NH: begin
                if (accept) begin
                    addr_d  = ADDR_W'(cnt_q);
                    wdata_d = bus.wr_data;
                    csum_d  = load_checksum + bus.wr_data;
                    if (state_q == LOAD_BB) begin
                        bbr_we_d = 4'hF;
                    end else begin
                        nhr_we_d = 4'hF;
                    end
                    if (cnt_q == (len_q - LEN_W'(1))) begin
                        cnt_d = '0;
                        if (state_q == LOAD_BB) begin
                            state_d = LOAD_NH;
                        end else begin
                            // Last strobe still needs the port next cycle; only the reset drops now.
                            state_d     = SETTLE;
                            settle_d    = '0;
                            mon_reset_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            SETTLE: begin
                sel_d = 1'b0;
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A drop counted in the clearing cycle survives the clear.
        if (alarm_clear) begin
            alarm_d = counted;
            count_d = CNT_W'(counted);
        end
    end

    // State and registered outputs.
    always_ff @(posedge core_sp_clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            settle_q      <= '0;
            bus.mem_sel   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.bbr_we    <= '0;
            bus.nhr_we    <= '0;
            mon_reset     <= 1'b1;
            pkt_drop      <= 1'b0;
            alarm         <= 1'b0;
            alarm_count   <= '0;
            load_checksum <= '0;
            load_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            settle_q      <= settle_d;
            bus.mem_sel   <= sel_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            bus.bbr_we    <= bbr_we_d;
            bus.nhr_we    <= nhr_we_d;
            mon_reset     <= mon_reset_d;
            pkt_drop      <= pkt_drop_d;
            alarm         <= alarm_d;
            alarm_count   <= count_d;
            load_checksum <= csum_d;
            load_done     <= load_done_d;
        end
    end
endmodule

// File: tb/tb_sec_monitor_ctrl.sv
// Directed + randomized bench for sec_monitor_ctrl against a behavioural model.
module tb_sec_monitor_ctrl;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 4;
    localparam int DEPTH  = 2048;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              mon_reset;
    logic              drop_packet = 1'b0;
    logic              pkt_drop;
    logic              alarm;
    logic              alarm_clear = 1'b0;
    logic [CNT_W-1:0]  alarm_count;
    logic [DATA_W-1:0] load_checksum;
    logic              load_done;
    logic              busy;

    sec_monitor_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sec_monitor_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
        .core_sp_clk   (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_len      (load_len),
        .bus           (bus.slave),
        .mon_reset     (mon_reset),
        .drop_packet   (drop_packet),
        .pkt_drop      (pkt_drop),
        .alarm         (alarm),
        .alarm_clear   (alarm_clear),
        .alarm_count   (alarm_count),
        .load_checksum (load_checksum),
        .load_done     (load_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              sel;
    } wr_t;

    wr_t bbq[$];
    wr_t nhq[$];

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    bit m_alarm = 1'b0;

    // Record every RAM write strobe seen on the port.
    always begin
        @(posedge clk);
        #1;
        if (bus.bbr_we != 4'h0) bbq.push_back({bus.bbr_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel});
        if (bus.nhr_we != 4'h0) nhq.push_back({bus.nhr_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One RUN-state cycle with the alarm model updated from the rules.
    task automatic run_cycle(input bit drop, input bit clr, input string tag);
        drop_packet = drop;
        alarm_clear = clr;
        step();
        if (clr) begin
            m_alarm = drop;
            m_cnt   = drop ? 1 : 0;
        end else if (drop) begin
            m_alarm = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
        chk({tag, "_pkt_drop"}, 64'(pkt_drop), 64'(drop));
        chk({tag, "_alarm"}, 64'(alarm), 64'(m_alarm));
        chk({tag, "_count"}, 64'(alarm_count), 64'(m_cnt));
        drop_packet = 1'b0;
        alarm_clear = 1'b0;
    endtask

    // Full table load; expected writes/checksum/timing derived from the word list.
    task automatic do_load(input int len, input bit gappy, input bit mid_start, input bit settle_drop, input string tag);
        int eff, idx, cyc, last_acc, done_cyc, mr_fall, ms_fall, bad;
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] sum;
        bit pd_seen, acc;
        eff = (len > DEPTH) ? DEPTH : len;
        words.delete();
        sum = '0;
        for (int i = 0; i < 2 * eff; i++) begin
            words.push_back($urandom);
            sum = sum + words[i];
        end
        bbq.delete();
        nhq.delete();
        idx = 0; last_acc = -1; done_cyc = -1; mr_fall = -1; ms_fall = -1; pd_seen = 1'b0;
        load_len   = (ADDR_W+1)'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        cyc = 0;
        chk({tag, "_mon_reset_start"}, 64'(mon_reset), 64'(1));
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        while (done_cyc < 0 && cyc < 10000) begin
            bus.wr_valid = (idx < 2 * eff) && (gappy ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.wr_data  = (idx < 2 * eff) ? words[idx] : '0;
            load_start   = mid_start && (cyc == 2);
            if (mid_start && cyc == 2) load_len = (ADDR_W+1)'(5);
            drop_packet  = settle_drop && (last_acc >= 0) && (cyc == last_acc + 1);
            acc = bus.wr_valid && bus.wr_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 2 * eff) last_acc = cyc;
            end
            if (mon_reset == 1'b0 && mr_fall < 0) mr_fall = cyc;
            if (last_acc >= 0 && bus.mem_sel == 1'b0 && ms_fall < 0) ms_fall = cyc;
            if (pkt_drop) pd_seen = 1'b1;
            if (load_done) done_cyc = cyc;
        end
        bus.wr_valid = 1'b0;
        load_start   = 1'b0;
        drop_packet  = 1'b0;
        chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
        chk({tag, "_done_time"}, 64'(done_cyc), 64'(last_acc + SETTLE));
        if (!gappy && !mid_start)
            chk({tag, "_done_from_start"}, 64'(done_cyc + 1), 64'(1 + 2 * eff + SETTLE));
        chk({tag, "_mon_reset_fall"}, 64'(mr_fall), 64'(last_acc));
        chk({tag, "_mem_sel_fall"}, 64'(ms_fall), 64'(last_acc + 1));
        chk({tag, "_checksum"}, 64'(load_checksum), 64'(sum));
        chk({tag, "_bb_writes"}, 64'(bbq.size()), 64'(eff));
        chk({tag, "_nh_writes"}, 64'(nhq.size()), 64'(eff));
        bad = 0;
        for (int i = 0; i < eff && i < bbq.size(); i++)
            if (bbq[i] !== {4'hF, ADDR_W'(i), words[i], 1'b1}) bad++;
        for (int i = 0; i < eff && i < nhq.size(); i++)
            if (nhq[i] !== {4'hF, ADDR_W'(i), words[eff + i], 1'b1}) bad++;
        chk({tag, "_bad_writes"}, 64'(bad), 64'(0));
        chk({tag, "_no_pkt_drop"}, 64'(pd_seen), 64'(0));
        chk({tag, "_alarm_kept"}, 64'(alarm), 64'(m_alarm));
        chk({tag, "_count_kept"}, 64'(alarm_count), 64'(m_cnt));
        chk({tag, "_busy_run"}, 64'(busy), 64'(0));
        chk({tag, "_ready_run"}, 64'(bus.wr_ready), 64'(0));
        run_cycle(1'b0, 1'b0, {tag, "_post"});
        chk({tag, "_done_pulse"}, 64'(load_done), 64'(0));
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        reset = 1'b0;
        step();
        step();
        chk("rst_mon_reset", 64'(mon_reset), 64'(1));
        chk("rst_mem_sel", 64'(bus.mem_sel), 64'(0));
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'(0));
        chk("rst_bbr_we", 64'(bus.bbr_we), 64'(0));
        chk("rst_nhr_we", 64'(bus.nhr_we), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_pkt_drop", 64'(pkt_drop), 64'(0));
        chk("rst_alarm", 64'(alarm), 64'(0));
        chk("rst_count", 64'(alarm_count), 64'(0));
        chk("rst_checksum", 64'(load_checksum), 64'(0));
        chk("rst_load_done", 64'(load_done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        step();

        // Basic load with a drop pulse in the second settle cycle.
        do_load(3, 1'b0, 1'b0, 1'b1, "load3");
        run_cycle(1'b1, 1'b0, "run_drop1");
        run_cycle(1'b0, 1'b0, "run_idle1");

        // Reload from RUN with a stalling host and an ignored mid-load start.
        do_load(3, 1'b1, 1'b1, 1'b0, "gappy3");

        // Random drops and clears in RUN.
        for (int i = 0; i < 200; i++)
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, "rand_run");

        // Counter saturation then clear coinciding with a drop.
        for (int i = 0; i < (1 << CNT_W) + 5; i++) run_cycle(1'b1, 1'b0, "sat");
        chk("sat_count", 64'(alarm_count), 64'(CMAX));
        run_cycle(1'b1, 1'b1, "clr_drop");
        chk("clr_drop_count", 64'(alarm_count), 64'(1));
        run_cycle(1'b0, 1'b0, "after_clr");

        // Zero-length start is ignored; still in RUN.
        load_len   = '0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_mon_reset", 64'(mon_reset), 64'(0));
        step();
        chk("len0_ready", 64'(bus.wr_ready), 64'(0));
        run_cycle(1'b1, 1'b0, "len0_run");

        // Oversized length clamps to the table depth.
        do_load(4095, 1'b0, 1'b0, 1'b0, "len4095");

        // A few random-length stalled loads.
        for (int i = 0; i < 3; i++) do_load($urandom_range(1, 20), 1'b1, 1'b0, 1'b0, "randlen");

        // Reset asserted while loading the next-hop table.
        load_len   = (ADDR_W+1)'(3);
        load_start = 1'b1;
        step();
        load_start   = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) step();
        chk("abort_busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        step();
        m_alarm = 1'b0;
        m_cnt   = 0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_mon_reset", 64'(mon_reset), 64'(1));
        chk("abort_mem_sel", 64'(bus.mem_sel), 64'(0));
        chk("abort_we", 64'({bus.bbr_we, bus.nhr_we}), 64'(0));
        chk("abort_count", 64'(alarm_count), 64'(0));
        chk("abort_ready", 64'(bus.wr_ready), 64'(0));
        reset = 1'b1;
        step();

        // Recovery load after the abort.
        do_load(2, 1'b0, 1'b0, 1'b0, "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sec_monitor_ctrl.md
Name: sec_monitor_ctrl

Overview:
- Sequences the per-core security monitor: holds the monitor in reset, loads the basic-block and next-hop graph tables through the shared RAM write port, then arms the monitor.
- After arming, gates and counts drop_packet alarms.
- Sits between the host register block and one sec_monitor instance.
- Owns the RAM port-select while loading: mem_sel=1 means the loader drives addr/we; mem_sel=0 means the monitor's stage1/stage3 drive them.

Parameters:
- ADDR_W, 11, word address width; covers byte address bits 12:2.
- DATA_W, 32, table word width.
- CNT_W, 16, alarm counter width.
- SETTLE_CYCLES, 4, cycles after monitor reset release during which drop_packet is ignored (pipeline fill).

Ports:
- core_sp_clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  single-cycle load request.
- load_len  in  ADDR_W+1  words per table (applies to both tables).
- wr_valid  in  1  host word valid.
- wr_data  in  DATA_W  host word.
- wr_ready  out  1  controller accepts word.
- mem_sel  out  1  loader owns RAM port.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- bbr_we  out  4  bb_ram byte enables.
- nhr_we  out  4  next_hop_ram byte enables.
- mon_reset  out  1  active-high reset to sec_monitor.
- drop_packet  in  1  monitor violation.
- pkt_drop  out  1  gated drop to packet processor.
- alarm  out  1  sticky violation flag.
- alarm_clear  in  1  clears alarm and alarm_count.
- alarm_count  out  CNT_W  saturating violation count.
- load_checksum  out  DATA_W  sum mod 2^DATA_W of all loaded words.
- load_done  out  1  one-cycle pulse on entering RUN.
- busy  out  1  state is not IDLE and not RUN.

Behaviour:
- Reset (reset==0 at clock edge): state IDLE; mon_reset=1, mem_sel=0, wr_ready=0, bbr_we=nhr_we=0, mem_addr=0, mem_wdata=0, pkt_drop=0, alarm=0, alarm_count=0, load_checksum=0, load_done=0, busy=0.
- Reset mid-load abandons the load and returns to IDLE. Partially written RAM contents are undefined.
- All outputs are registered except wr_ready and busy, which decode the current state.
- States: IDLE, LOAD_BB, LOAD_NH, SETTLE, RUN.
- IDLE / RUN + load_start, with eff_len != 0 -> LOAD_BB:
  - eff_len = min(load_len, 2^ADDR_W), sampled on start.
  - cnt=0, load_checksum=0, mon_reset=1, mem_sel=1.
- load_start with load_len==0 is ignored.
- load_start in LOAD_BB, LOAD_NH or SETTLE is ignored.
- LOAD_BB: wr_ready=1. On accept (wr_valid & wr_ready):
  - next cycle drives mem_addr=cnt, mem_wdata=wr_data, bbr_we=4'hF for exactly one cycle;
  - load_checksum += wr_data; cnt++.
  - Accepting word eff_len-1 -> LOAD_NH with cnt=0.
  - Host may stall (wr_valid=0) indefinitely; no timeout.
- LOAD_NH: identical, using nhr_we. The last accept -> SETTLE.
  - The final write strobe still issues in the first SETTLE cycle; mem_sel stays 1 for that cycle.
- SETTLE:
  - mem_sel=0 from the second SETTLE cycle onward.
  - mon_reset=0 from the first SETTLE cycle.
  - drop_packet ignored for SETTLE_CYCLES cycles, then -> RUN with load_done=1 for one cycle.
- RUN:
  - pkt_drop = drop_packet delayed one cycle.
  - On drop_packet: alarm<=1; alarm_count increments, saturating at 2^CNT_W-1.
- Outside RUN, pkt_drop=0 and drop_packet has no effect.
- alarm_clear (any state) sets alarm<=0, alarm_count<=0.
  - If asserted in the same cycle as a counted drop_packet: alarm<=1, alarm_count<=1.
- Reload from RUN: mon_reset reasserts the cycle after load_start. alarm and alarm_count are preserved.

Test Plan:
- Reset, then load_start with load_len=3, words A,B,C then D,E,F, wr_valid held -> bbr_we pulses at addr 0,1,2; nhr_we pulses at addr 0,1,2; load_checksum=A+B+C+D+E+F; load_done 1+3+3+SETTLE_CYCLES cycles after start (accounting for the registered strobe); mon_reset falls on first SETTLE cycle.
- During load, toggle wr_valid 1-0-1 and pulse load_start mid-load -> no duplicate or skipped addresses; second start ignored; cnt unaffected.
- drop_packet pulsed in SETTLE cycle 2, then in RUN -> first ignored; second gives pkt_drop one cycle later, alarm=1, alarm_count=1.
- In RUN, hold drop_packet high for 2^CNT_W+5 cycles (use CNT_W=4) -> alarm_count sticks at 15; then alarm_clear together with drop_packet -> count=1, alarm=1.
- load_len=0 -> no state change. load_len=4095 -> 2048 writes per table, mem_addr wraps to no value beyond 2047.
- Assert reset=0 in the middle of LOAD_NH -> next cycle IDLE, mon_reset=1, mem_sel=0, all we=0, alarm_count=0.
